// File: rtl/loba_pkg.sv
// Shared constants, FSM/term encodings and the split-operand record for the LOBA merge stage.
// A segment's LSB sits at bit weight k-K_BIAS; indices below K_BIAS clamp to weight 0.
package loba_pkg;

  localparam int SEG_W  = 4;
  localparam int K_W    = 4;
  localparam int P_W    = 32;
  localparam int K_BIAS = 3;

  localparam logic [K_W-1:0] K_BIAS_K = K_W'(K_BIAS);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [1:0] {
    TERM_HH = 2'd0,
    TERM_HL = 2'd1,
    TERM_LH = 2'd2,
    TERM_LL = 2'd3
  } term_t;

  typedef struct packed {
    logic [SEG_W-1:0] xh;
    logic [K_W-1:0]   kh;
    logic [SEG_W-1:0] xl;
    logic [K_W-1:0]   kl;
  } split_t;

  function automatic logic [K_W:0] seg_shift(input logic [K_W-1:0] k);
    seg_shift = (k < K_BIAS_K) ? '0 : {1'b0, k - K_BIAS_K};
  endfunction

endpackage

// File: rtl/loba_pp_term.sv
// One LOBA cross-product term: segment product moved back to its bit weight, combinational.
// An absent segment (k == 0) on either side contributes nothing.
module loba_pp_term
  import loba_pkg::*;
(
  input  logic [SEG_W-1:0] xa,
  input  logic [K_W-1:0]   ka,
  input  logic [SEG_W-1:0] xb,
  input  logic [K_W-1:0]   kb,
  output logic [P_W-1:0]   term
);

  logic [2*SEG_W-1:0] prod;
  logic [K_W:0]       sh;

  always_comb begin
    prod = (2*SEG_W)'(xa) * (2*SEG_W)'(xb);
    sh   = seg_shift(ka) + seg_shift(kb);
    if (ka == '0 || kb == '0)
      term = '0;
    else
      term = {{(P_W-2*SEG_W){1'b0}}, prod} << sh;
  end

endmodule

// File: rtl/loba_merge_mult.sv
// LOBA back end: four serial cross-product accumulates, result out 5 edges after accept.
// Holds in_ready low from accept until the product is taken; p holds while out_ready is low.
module loba_merge_mult
  import loba_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEG_W-1:0] a_xh,
  input  logic [K_W-1:0]   a_kh,
  input  logic [SEG_W-1:0] a_xl,
  input  logic [K_W-1:0]   a_kl,
  input  logic [SEG_W-1:0] b_xh,
  input  logic [K_W-1:0]   b_kh,
  input  logic [SEG_W-1:0] b_xl,
  input  logic [K_W-1:0]   b_kl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   p
);

  state_t           state, state_nxt;
  term_t            idx;
  split_t           a_q, b_q;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   p_q;
  logic             acc_done;
  logic [SEG_W-1:0] xa, xb;
  logic [K_W-1:0]   ka, kb;
  logic [P_W-1:0]   term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        if (acc_done) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand selection for the single shared term generator.
  always_comb begin
    xa = a_q.xh;
    ka = a_q.kh;
    xb = b_q.xh;
    kb = b_q.kh;
    case (idx)
      TERM_HL: begin xb = b_q.xl; kb = b_q.kl; end
      TERM_LH: begin xa = a_q.xl; ka = a_q.kl; end
      TERM_LL: begin
        xa = a_q.xl; ka = a_q.kl;
        xb = b_q.xl; kb = b_q.kl;
      end
      default: ;
    endcase
  end

  loba_pp_term u_term (
    .xa   (xa),
    .ka   (ka),
    .xb   (xb),
    .kb   (kb),
    .term (term)
  );

  // acc_done marks that the ll term is in; the following MUL cycle moves acc to p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      idx      <= TERM_HH;
      acc_done <= 1'b0;
      p_q      <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q      <= '{xh: a_xh, kh: a_kh, xl: a_xl, kl: a_kl};
      b_q      <= '{xh: b_xh, kh: b_kh, xl: b_xl, kl: b_kl};
      acc      <= '0;
      idx      <= TERM_HH;
      acc_done <= 1'b0;
    end else if (state == MUL) begin
      if (!acc_done) begin
        acc      <= acc + term;
        idx      <= term_t'(idx + 2'd1);
        acc_done <= (idx == TERM_LL);
      end else begin
        p_q      <= acc;
        acc_done <= 1'b0;
      end
    end
  end

  assign p = p_q;

endmodule
